// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed driver for a 4-digit common-anode
// 7-segment display.
//
// A refresh counter walks the four digits round-robin. Each digit slot
// is DIGIT_CYCLES clocks long. The first BLANK_CYCLES clocks of a slot
// keep every anode off, so the cathodes can settle without ghosting
// into the neighbouring digit. The display value, enables and decimal
// points are captured once per frame, when the digit index wraps 3->0,
// so a frame is never torn by input changes part-way through.
//
// All board-facing outputs are registered. They lag the (cnt, idx)
// scan position by one clock.
//
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN
//   defined   - digit k (k=3..1) goes dark when the snapshot nibbles
//               k..3 are all zero. Digit 0 is never suppressed.
//   undefined - leading zeros show as "0", subject to digit_en only.

module seg_scan_mux #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  // Slot counter sizing. DIGIT_CYCLES >= 2 keeps the width at 1 or more.
  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  // Idle patterns for the active-low pins.
  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // ------------------------------------------------------------------
  // Hex nibble to active-low cathode pattern, seg[0]=a .. seg[6]=g.
  // ------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // ------------------------------------------------------------------
  // Effective per-digit enable, taken from the frame snapshot.
  // With leading-zero blanking, a digit is dark when it and every
  // more-significant nibble are zero. Digit 0 always follows digit_en.
  // ------------------------------------------------------------------
  function automatic logic [3:0] effective_en(input logic [15:0] v,
                                              input logic [3:0]  en);
    logic [3:0] e;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    e[0] = en[0];
    e[1] = en[1] & (v[15:4]  != 12'h000);
    e[2] = en[2] & (v[15:8]  != 8'h00);
    e[3] = en[3] & (v[15:12] != 4'h0);
`else
    e = en;
`endif
    return e;
  endfunction

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;

  logic [15:0]      val_snap_q, val_snap_d;
  logic [3:0]       en_snap_q,  en_snap_d;
  logic [3:0]       dp_snap_q,  dp_snap_d;

  logic [3:0]       an_q,  an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q,  dp_d;
  logic             frame_tick_q, frame_tick_d;

  // Decoded scan position and current-digit attributes.
  logic             slot_end_s;
  logic             frame_wrap_s;
  logic             blank_s;
  logic [3:0]       eff_en_s;
  logic [3:0]       nibble_s;
  logic             digit_on_s;

  // Scan position: advance cnt and move to the next digit at slot end.
  always_comb begin
    slot_end_s   = (cnt_q == CNT_LAST);
    frame_wrap_s = slot_end_s && (idx_q == 2'd3);
    if (slot_end_s) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
  end

  // Frame snapshot: capture inputs only on the 3->0 index wrap.
  always_comb begin
    if (frame_wrap_s) begin
      val_snap_d = value;
      en_snap_d  = digit_en;
      dp_snap_d  = dp_in;
    end else begin
      val_snap_d = val_snap_q;
      en_snap_d  = en_snap_q;
      dp_snap_d  = dp_snap_q;
    end
    frame_tick_d = frame_wrap_s;
  end

  // Digit selection: pick the phase, nibble and enable for this slot.
  always_comb begin
    blank_s    = (cnt_q < BLANK_END);
    eff_en_s   = effective_en(val_snap_q, en_snap_q);
    nibble_s   = val_snap_q[{idx_q, 2'b00} +: 4];
    digit_on_s = (!blank_s) && eff_en_s[idx_q];
  end

  // Pin pattern: one anode low only in the ACTIVE phase of an enabled digit.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (digit_on_s) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex_to_seg(nibble_s);
      dp_d  = ~dp_snap_q[idx_q];
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  // Scan position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Snapshot registers. They reset to zero, so the first frame is dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_snap_q <= 16'h0000;
      en_snap_q  <= 4'h0;
      dp_snap_q  <= 4'h0;
    end else begin
      val_snap_q <= val_snap_d;
      en_snap_q  <= en_snap_d;
      dp_snap_q  <= dp_snap_d;
    end
  end

  // Output registers: all pins are idle as soon as reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux with DIGIT_CYCLES=8 and BLANK_CYCLES=2.
// The reference model works from the clock count since reset release:
// slot = (p/8)%4 and phase = p%8. It takes a snapshot every 32 cycles.
module tb_seg_scan_mux;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * DC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  digit_en = 4'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          n = 0;
  logic [15:0] m_val = 16'h0000;
  logic [3:0]  m_en = 4'h0;
  logic [3:0]  m_dp = 4'h0;

  // Per-frame observations.
  logic [6:0]  last_seg [4];
  logic        last_dp [4];
  int          active_cnt [4];
  int          tick_cnt;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 clk = ~clk;

  seg_scan_mux #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  function automatic logic [3:0] eff_en(input logic [15:0] v, input logic [3:0] en);
    logic [3:0] e;
    e = en;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    for (int k = 1; k < 4; k++) begin
      if ((v >> (4 * k)) == 16'd0) e[k] = 1'b0;
    end
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    for (int k = 0; k < 4; k++) begin
      last_seg[k]   = 7'h7F;
      last_dp[k]    = 1'b1;
      active_cnt[k] = 0;
    end
    tick_cnt = 0;
  endtask

  // One clock: predict the outputs, compare them, and record observations.
  task automatic step();
    int p;
    int slot;
    int ph;
    logic [3:0] en;
    logic [3:0] nib;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_ft;
    @(posedge clk);
    p    = n;
    slot = (p / DC) % 4;
    ph   = p % DC;
    en   = eff_en(m_val, m_en);
    nib  = m_val[4 * slot +: 4];
    if (ph >= BC && en[slot]) begin
      e_an  = ~(4'b0001 << slot);
      e_seg = hex_tab[nib];
      e_dp  = ~m_dp[slot];
    end else begin
      e_an  = 4'b1111;
      e_seg = 7'b1111111;
      e_dp  = 1'b1;
    end
    e_ft = (((p + 1) % FRAME) == 0);
    if (e_ft) begin
      m_val = value;
      m_en  = digit_en;
      m_dp  = dp_in;
    end
    n++;
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("frame_tick", 32'(frame_tick), 32'(e_ft));
    if (frame_tick === 1'b1) tick_cnt++;
    for (int k = 0; k < 4; k++) begin
      if (an[k] === 1'b0) begin
        active_cnt[k]++;
        last_seg[k] = seg;
        last_dp[k]  = dp;
      end
    end
  endtask

  task automatic model_reset();
    n     = 0;
    m_val = 16'h0000;
    m_en  = 4'h0;
    m_dp  = 4'h0;
  endtask

  initial begin
    int first;
    int i;
    clear_obs();

    // Power-on reset with the first stimulus already applied.
    value    = 16'h1A80;
    digit_en = 4'b1111;
    dp_in    = 4'b0010;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'h F);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    model_reset();

    // The first frame is dark. The first tick comes after 32 clocks.
    first = -1;
    i = 0;
    while (first < 0 && i < 40) begin
      step();
      i++;
      if (frame_tick === 1'b1) first = i;
    end
    check("first_tick_cycle", 32'(first), 32'd32);

    // Decode sweep on the 1A80 frame.
    clear_obs();
    repeat (FRAME) step();
    check("d0_seg", 32'(last_seg[0]), 32'(7'b1000000));
    check("d0_dp", 32'(last_dp[0]), 32'd1);
    check("d1_seg", 32'(last_seg[1]), 32'(7'b0000000));
    check("d1_dp", 32'(last_dp[1]), 32'd0);
    check("d2_seg", 32'(last_seg[2]), 32'(7'b0001000));
    check("d3_seg", 32'(last_seg[3]), 32'(7'b1111001));
    for (int k = 0; k < 4; k++) check("active_len", 32'(active_cnt[k]), 32'd6);
    check("tick_per_frame", 32'(tick_cnt), 32'd1);

    // Tearing: change value during digit 1's ACTIVE phase.
    clear_obs();
    repeat (12) step();
    value = 16'hFFFF;
    repeat (FRAME - 12) step();
    check("tear_d1", 32'(last_seg[1]), 32'(7'b0000000));
    check("tear_d2", 32'(last_seg[2]), 32'(7'b0001000));
    check("tear_d3", 32'(last_seg[3]), 32'(7'b1111001));
    clear_obs();
    repeat (FRAME) step();
    for (int k = 0; k < 4; k++) check("ffff_seg", 32'(last_seg[k]), 32'(7'b0001110));

    // Reset asserted in the middle of digit 0's ACTIVE phase.
    repeat (4) step();
    check("pre_rst_active", 32'(an), 32'(4'b1110));
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_seg", 32'(seg), 32'h7F);
    check("mid_rst_dp", 32'(dp), 32'h1);
    check("mid_rst_tick", 32'(frame_tick), 32'h0);
    value    = 16'h1A80;
    digit_en = 4'b0101;
    dp_in    = 4'b0000;
    #2;
    rst_n = 1'b1;
    model_reset();

    // Enables 0101: digits 1 and 3 stay dark, but their slots keep their timing.
    repeat (FRAME) step();
    clear_obs();
    repeat (FRAME) step();
    check("en_d0_len", 32'(active_cnt[0]), 32'd6);
    check("en_d1_len", 32'(active_cnt[1]), 32'd0);
    check("en_d2_len", 32'(active_cnt[2]), 32'd6);
    check("en_d3_len", 32'(active_cnt[3]), 32'd0);
    check("en_d0_seg", 32'(last_seg[0]), 32'(7'b1000000));
    check("en_d2_seg", 32'(last_seg[2]), 32'(7'b0001000));

    // Leading zeros with value 0042.
    value    = 16'h0042;
    digit_en = 4'b1111;
    repeat (FRAME) step();
    clear_obs();
    repeat (FRAME) step();
    check("lz_d1_seg", 32'(last_seg[1]), 32'(7'b0011001));
    check("lz_d0_seg", 32'(last_seg[0]), 32'(7'b0100100));
`ifdef SEG_LEADING_ZERO_BLANK_EN
    check("lz_d3_len", 32'(active_cnt[3]), 32'd0);
    check("lz_d2_len", 32'(active_cnt[2]), 32'd0);
`else
    check("lz_d3_seg", 32'(last_seg[3]), 32'(7'b1000000));
    check("lz_d2_seg", 32'(last_seg[2]), 32'(7'b1000000));
`endif

    // Randomized inputs that change at random cycles.
    for (int f = 0; f < 20; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        step();
        if ($urandom_range(0, 7) == 0) value = 16'($urandom);
        if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
        if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
